// File: rtl/mesi_snoop_bus_ctrl.sv
// Shared-bus controller for MESI caches: round-robin arbitration, snoop broadcast,
// response collection, write-back/fill sequencing. Optional watchdog: MESI_BUS_TIMEOUT_EN.
module mesi_snoop_bus_ctrl #(
    parameter int N_CACHES    = 4,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                         clk,
    input  logic                         rstb,
    input  logic [N_CACHES-1:0]          req_valid,
    input  logic [2*N_CACHES-1:0]        req_type,
    input  logic [ADDR_W*N_CACHES-1:0]   req_addr,
    output logic [N_CACHES-1:0]          grant,
    output logic                         snoop_valid,
    output logic [1:0]                   snoop_type,
    output logic [ADDR_W-1:0]            snoop_addr,
    output logic [N_CACHES-1:0]          snoop_src,
    input  logic [N_CACHES-1:0]          C_resp,
    input  logic [N_CACHES-1:0]          flush_resp,
    output logic                         mem_wr_req,
    input  logic                         mem_wr_ack,
    output logic                         mem_rd_req,
    input  logic                         mem_rd_ack,
    output logic [N_CACHES-1:0]          done,
    output logic                         shared,
    output logic                         bus_err
);

    localparam int IDX_W = (N_CACHES > 1) ? $clog2(N_CACHES) : 1;
    localparam int CW    = IDX_W + 1;
    localparam logic [N_CACHES-1:0] ONE_N = {{(N_CACHES-1){1'b0}}, 1'b1};

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SNOOP = 3'd1;
    localparam logic [2:0] ST_RESP  = 3'd2;
    localparam logic [2:0] ST_WB    = 3'd3;
    localparam logic [2:0] ST_MEM   = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    logic [2:0]          state_q, state_d;
    logic [IDX_W-1:0]    rr_q, rr_d;
    logic [IDX_W-1:0]    win_q, win_d;
    logic [1:0]          type_q, type_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                shared_q, shared_d;

    logic                arb_hit_s;
    logic [IDX_W-1:0]    arb_idx_s;
    logic [CW-1:0]       cand_s;
    logic [N_CACHES-1:0] win_oh_s;
    logic [N_CACHES-1:0] mask_c_s;
    logic [N_CACHES-1:0] mask_f_s;
    logic                ack_s;

`ifdef MESI_BUS_TIMEOUT_EN
    logic [7:0]          cnt_q, cnt_d;
    logic                err_q, err_d;

    function automatic logic multi_hot(input logic [N_CACHES-1:0] v);
        return |(v & (v - ONE_N));
    endfunction
`endif

    assign win_oh_s = ONE_N << win_q;
    assign mask_c_s = C_resp & ~win_oh_s;
    assign mask_f_s = flush_resp & ~win_oh_s;
    assign ack_s    = (state_q == ST_WB) ? mem_wr_ack : mem_rd_ack;

    // Round-robin search: lowest offset from rr_q wins, so scan offsets high to low.
    always_comb begin
        arb_hit_s = 1'b0;
        arb_idx_s = '0;
        cand_s    = '0;
        for (int i = N_CACHES - 1; i >= 0; i--) begin
            cand_s = {1'b0, rr_q} + CW'(i);
            if (cand_s >= CW'(N_CACHES)) begin
                cand_s = cand_s - CW'(N_CACHES);
            end else begin
                cand_s = cand_s;
            end
            if (req_valid[cand_s[IDX_W-1:0]]) begin
                arb_hit_s = 1'b1;
                arb_idx_s = cand_s[IDX_W-1:0];
            end else begin
                arb_hit_s = arb_hit_s;
            end
        end
    end

    // Transaction sequencing and latching of the winning request.
    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        win_d    = win_q;
        type_d   = type_q;
        addr_d   = addr_q;
        shared_d = shared_q;
`ifdef MESI_BUS_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (arb_hit_s) begin
                    win_d   = arb_idx_s;
                    type_d  = req_type[2*arb_idx_s +: 2];
                    addr_d  = req_addr[ADDR_W*arb_idx_s +: ADDR_W];
                    rr_d    = (arb_idx_s == IDX_W'(N_CACHES - 1)) ? '0 : arb_idx_s + IDX_W'(1);
                    state_d = ST_SNOOP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SNOOP: state_d = ST_RESP;
            ST_RESP: begin
                shared_d = (type_q == 2'b01) && ((mask_c_s | mask_f_s) != '0);
`ifdef MESI_BUS_TIMEOUT_EN
                cnt_d = 8'd0;
                if (multi_hot(mask_f_s)) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
`endif
                if (mask_f_s != '0) begin
                    state_d = ST_WB;
                end else if ((type_q == 2'b01) || (type_q == 2'b10)) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_WB, ST_MEM: begin
                if (ack_s) begin
                    state_d = ST_DONE;
                end else begin
`ifdef MESI_BUS_TIMEOUT_EN
                    if (cnt_q == 8'(TIMEOUT_CYC - 1)) begin
                        state_d  = ST_DONE;
                        shared_d = 1'b0;
                        err_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
`else
                    state_d = state_q;
`endif
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and latched transaction fields.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q  <= ST_IDLE;
            rr_q     <= '0;
            win_q    <= '0;
            type_q   <= 2'b00;
            addr_q   <= '0;
            shared_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            win_q    <= win_d;
            type_q   <= type_d;
            addr_q   <= addr_d;
            shared_q <= shared_d;
        end
    end

`ifdef MESI_BUS_TIMEOUT_EN
    // Watchdog counter and sticky error flag.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cnt_q <= 8'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign bus_err = err_q;
`else
    assign bus_err = 1'b0;
`endif

    assign grant       = (state_q != ST_IDLE)  ? win_oh_s : '0;
    assign snoop_valid = (state_q == ST_SNOOP);
    assign snoop_type  = (state_q == ST_SNOOP) ? type_q : 2'b00;
    assign snoop_addr  = (state_q == ST_SNOOP) ? addr_q : '0;
    assign snoop_src   = (state_q == ST_SNOOP) ? win_oh_s : '0;
    assign mem_wr_req  = (state_q == ST_WB);
    assign mem_rd_req  = (state_q == ST_MEM);
    assign done        = (state_q == ST_DONE)  ? win_oh_s : '0;
    assign shared      = (state_q == ST_DONE) && shared_q;

endmodule

// File: tb/tb_mesi_snoop_bus_ctrl.sv
// Randomized self-checking bench for mesi_snoop_bus_ctrl with a transaction-level model.
module tb_mesi_snoop_bus_ctrl;

    localparam int N       = 4;
    localparam int AW      = 32;
    localparam int TIMEOUT = 64;

    logic              clk = 1'b0;
    logic              rstb;
    logic [N-1:0]      req_valid;
    logic [2*N-1:0]    req_type;
    logic [AW*N-1:0]   req_addr;
    logic [N-1:0]      grant;
    logic              snoop_valid;
    logic [1:0]        snoop_type;
    logic [AW-1:0]     snoop_addr;
    logic [N-1:0]      snoop_src;
    logic [N-1:0]      C_resp;
    logic [N-1:0]      flush_resp;
    logic              mem_wr_req;
    logic              mem_wr_ack;
    logic              mem_rd_req;
    logic              mem_rd_ack;
    logic [N-1:0]      done;
    logic              shared;
    logic              bus_err;

    mesi_snoop_bus_ctrl #(.N_CACHES(N), .ADDR_W(AW), .TIMEOUT_CYC(TIMEOUT)) dut (
        .clk(clk), .rstb(rstb),
        .req_valid(req_valid), .req_type(req_type), .req_addr(req_addr),
        .grant(grant), .snoop_valid(snoop_valid), .snoop_type(snoop_type),
        .snoop_addr(snoop_addr), .snoop_src(snoop_src),
        .C_resp(C_resp), .flush_resp(flush_resp),
        .mem_wr_req(mem_wr_req), .mem_wr_ack(mem_wr_ack),
        .mem_rd_req(mem_rd_req), .mem_rd_ack(mem_rd_ack),
        .done(done), .shared(shared), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int           checks   = 0;
    int           failures = 0;
    logic [N-1:0] pend;
    logic [1:0]   ptype [N];
    logic [AW-1:0] paddr [N];
    int           rr_ptr;
    logic         exp_err;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_reqs();
        req_valid = pend;
        for (int i = 0; i < N; i++) begin
            req_type[2*i +: 2]   = ptype[i];
            req_addr[AW*i +: AW] = paddr[i];
        end
    endtask

    task automatic add_req(input int c, input logic [1:0] t, input logic [AW-1:0] a);
        pend[c]  = 1'b1;
        ptype[c] = t;
        paddr[c] = a;
    endtask

    // First pending cache at or after the round-robin pointer.
    function automatic int pick_winner();
        for (int off = 0; off < N; off++) begin
            if (pend[(rr_ptr + off) % N]) return (rr_ptr + off) % N;
        end
        return -1;
    endfunction

    // One full transaction, started from IDLE; a negative dly means no ack ever comes.
    task automatic run_txn(input logic [N-1:0] c_v, input logic [N-1:0] f_v, input int dly);
        int           w;
        int           path;
        int           waits;
        logic [N-1:0] oh;
        logic [N-1:0] mc;
        logic [N-1:0] mf;
        logic         exp_sh;
        drive_reqs();
        w  = pick_winner();
        oh = 4'b0001 << w;
        step();
        check_val("snoop_valid", 32'(snoop_valid), 32'd1);
        check_val("snoop_src",   32'(snoop_src),   32'(oh));
        check_val("grant_snoop", 32'(grant),       32'(oh));
        check_val("snoop_type",  32'(snoop_type),  32'(ptype[w]));
        check_val("snoop_addr",  snoop_addr,       paddr[w]);
        C_resp     = c_v;
        flush_resp = f_v;
        step();
        check_val("snoop_pulse", 32'(snoop_valid), 32'd0);
        check_val("grant_resp",  32'(grant),       32'(oh));
        check_val("mem_idle",    32'({mem_wr_req, mem_rd_req}), 32'd0);
        mc     = c_v & ~oh;
        mf     = f_v & ~oh;
        exp_sh = (ptype[w] == 2'b01) && ((mc | mf) != '0);
        if (mf != '0) path = 1;
        else if (ptype[w] == 2'b01 || ptype[w] == 2'b10) path = 2;
        else path = 0;
`ifdef MESI_BUS_TIMEOUT_EN
        if ($countones(mf) > 1) exp_err = 1'b1;
`endif
        step();
        C_resp     = 4'($urandom);
        flush_resp = 4'($urandom);
        if (path != 0) begin
            waits = (dly < 0) ? TIMEOUT : dly + 1;
            for (int j = 0; j < waits; j++) begin
                check_val("mem_wr_req", 32'(mem_wr_req), 32'(path == 1));
                check_val("mem_rd_req", 32'(mem_rd_req), 32'(path == 2));
                check_val("done_wait",  32'(done),       32'd0);
                mem_wr_ack = (path == 1) && (j == dly);
                mem_rd_ack = (path == 2) && (j == dly);
                step();
            end
            mem_wr_ack = 1'b0;
            mem_rd_ack = 1'b0;
            if (dly < 0) begin
                exp_sh  = 1'b0;
                exp_err = 1'b1;
            end
        end
        check_val("done",       32'(done),    32'(oh));
        check_val("shared",     32'(shared),  32'(exp_sh));
        check_val("grant_done", 32'(grant),   32'(oh));
        check_val("mem_done",   32'({mem_wr_req, mem_rd_req}), 32'd0);
        check_val("bus_err",    32'(bus_err), 32'(exp_err));
        pend[w] = 1'b0;
        rr_ptr  = (w + 1) % N;
        drive_reqs();
        C_resp     = '0;
        flush_resp = '0;
        step();
        check_val("done_pulse", 32'(done),   32'd0);
        check_val("grant_idle", 32'(grant),  32'd0);
        check_val("shared_idl", 32'(shared), 32'd0);
    endtask

    initial begin
        int w;
        rstb       = 1'b0;
        pend       = '0;
        rr_ptr     = 0;
        exp_err    = 1'b0;
        C_resp     = '0;
        flush_resp = '0;
        mem_wr_ack = 1'b0;
        mem_rd_ack = 1'b0;
        for (int i = 0; i < N; i++) begin
            ptype[i] = 2'b00;
            paddr[i] = '0;
        end
        drive_reqs();
        #12;
        check_val("rst_grant", 32'(grant),       32'd0);
        check_val("rst_snoop", 32'(snoop_valid), 32'd0);
        check_val("rst_mem",   32'({mem_wr_req, mem_rd_req}), 32'd0);
        check_val("rst_done",  32'({done, shared, bus_err}), 32'd0);
        #1 rstb = 1'b1;
        step();

        add_req(1, 2'b11, 32'h40);
        run_txn(4'b0100, 4'b0000, 0);
        add_req(0, 2'b01, 32'h80);
        run_txn(4'b0100, 4'b0000, 3);
        add_req(3, 2'b10, 32'h100);
        run_txn(4'b0000, 4'b0010, 2);

        for (int t = 0; t < 40; t++) begin
            for (int c = 0; c < N; c++) begin
                if (!pend[c] && ($urandom_range(0, 1) == 1))
                    add_req(c, 2'($urandom_range(0, 3)), $urandom);
            end
            if (pend == '0) add_req($urandom_range(0, N - 1), 2'($urandom_range(0, 3)), $urandom);
            run_txn(4'($urandom), 4'($urandom), $urandom_range(0, 4));
        end

`ifdef MESI_BUS_TIMEOUT_EN
        add_req(0, 2'b01, 32'h200);
        run_txn(4'b0000, 4'b0000, -1);
`endif

        // Reset while a fill is outstanding.
        for (int c = 0; c < N; c++) add_req(c, 2'b01, 32'h1000 + 32'(c));
        drive_reqs();
        w = pick_winner();
        step();
        C_resp     = '0;
        flush_resp = '0;
        step();
        step();
        check_val("pre_rst_rd", 32'(mem_rd_req), 32'd1);
        #2;
        rstb      = 1'b0;
        req_valid = '0;
        #1;
        check_val("mid_rst_grant", 32'(grant),      32'd0);
        check_val("mid_rst_rd",    32'(mem_rd_req), 32'd0);
        check_val("mid_rst_misc",  32'({snoop_valid, snoop_src, snoop_type, mem_wr_req, done, shared, bus_err}), 32'd0);
        check_val("mid_rst_addr",  snoop_addr, 32'd0);
        rr_ptr  = 0;
        exp_err = 1'b0;
        #3 rstb = 1'b1;
        step();

        // All four held: grants rotate 0,1,2,3,0.
        for (int t = 0; t < 5; t++) begin
            w = pick_winner();
            check_val("rr_order", 32'(w), 32'(t % N));
            run_txn(4'($urandom), 4'b0000, $urandom_range(0, 2));
            add_req(w, 2'b01, $urandom);
        end
        pend = '0;
        add_req(1, 2'b11, 32'h300);
        run_txn(4'b0000, 4'b0000, 0);
        add_req(1, 2'b11, 32'h304);
        add_req(3, 2'b11, 32'h308);
        run_txn(4'b0000, 4'b0000, 0);
        check_val("rr_skip_left", 32'(pend), 32'b0010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
